// File: rtl/spi_display_sequencer.sv
// rtl/spi_display_sequencer.sv - init-ROM and frame-stream byte sequencer for an SPI display
//
// Walks a 10-bit init ROM {type, payload} (00 cmd byte, 01 data byte,
// 10 delay of payload*MS_CYCLES clocks, 11 end), then streams frame bytes
// from a valid/ready source, one byte in flight at a time.
// Optional: define SEQ_WINDOW_CMD_EN to send the column/page window
// commands (21 00 7F 22 00 07) ahead of every frame.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle request to run the init sequence (IDLE only)
//   busy, init_done       status levels
//   pix_valid, pix_data   frame byte source
//   pix_ready             frame byte accepted when high together with pix_valid
//   frame_done            one-cycle pulse after the last byte of each frame
//   spi_data_out, dc_in   byte and D/C to the SPI master (registered)
//   spi_send              send request level to the SPI master
//   spi_send_done         completion level from the SPI master (slow, long)
module spi_display_sequencer #(
    parameter int ROM_DEPTH   = 32,
    parameter int MS_CYCLES   = 100000,
    parameter int FRAME_BYTES = 1024,
    parameter logic [ROM_DEPTH*10-1:0] ROM_INIT = {{(ROM_DEPTH-6){10'h300}},
        10'h300, 10'h0AF, 10'h20A, 10'h014, 10'h08D, 10'h0AE}
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       busy,
    output logic       init_done,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    output logic       frame_done,
    output logic [7:0] spi_data_out,
    output logic       dc_in,
    output logic       spi_send,
    input  logic       spi_send_done
);

    localparam int IDX_W  = $clog2(ROM_DEPTH + 1);
    localparam int DLY_W  = $clog2(255 * MS_CYCLES + 1);
    localparam int FCNT_W = $clog2(FRAME_BYTES) + 1;

    localparam logic [1:0] SRC_ROM = 2'd0;
    localparam logic [1:0] SRC_PIX = 2'd1;
    localparam logic [1:0] SRC_WIN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_WAIT_DONE,
        ST_WAIT_LOW,
        ST_DELAY,
`ifdef SEQ_WINDOW_CMD_EN
        ST_WINDOW,
`endif
        ST_STREAM
    } state_t;

    // State entered at the start of every frame.
`ifdef SEQ_WINDOW_CMD_EN
    localparam state_t ST_FRAME = ST_WINDOW;
`else
    localparam state_t ST_FRAME = ST_STREAM;
`endif

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DLY_W-1:0]   dly_q;
    logic [FCNT_W-1:0]  fcnt_q;
    logic [1:0]         src_q;
    logic [7:0]         data_q;
    logic               dc_q;
    logic               send_q;
    logic               busy_q;
    logic               init_done_q;
    logic               frame_done_q;
    logic [9:0]         rom_entry;
    logic [DLY_W-1:0]   dly_load;

`ifdef SEQ_WINDOW_CMD_EN
    logic [2:0] win_idx_q;

    function automatic logic [7:0] win_byte(input logic [2:0] i);
        case (i)
            3'd0:    win_byte = 8'h21;
            3'd1:    win_byte = 8'h00;
            3'd2:    win_byte = 8'h7F;
            3'd3:    win_byte = 8'h22;
            3'd4:    win_byte = 8'h00;
            default: win_byte = 8'h07;
        endcase
    endfunction
`endif

    // Out-of-range index reads as an end entry.
    always_comb begin
        rom_entry = 10'h300;
        for (int i = 0; i < ROM_DEPTH; i++) begin
            if (idx_q == IDX_W'(i)) rom_entry = ROM_INIT[i*10 +: 10];
        end
    end

    assign dly_load = DLY_W'(rom_entry[7:0]) * DLY_W'(MS_CYCLES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            dly_q        <= '0;
            fcnt_q       <= '0;
            src_q        <= SRC_ROM;
            data_q       <= 8'h00;
            dc_q         <= 1'b0;
            send_q       <= 1'b0;
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SEQ_WINDOW_CMD_EN
            win_idx_q    <= '0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (idx_q == IDX_W'(ROM_DEPTH) || rom_entry[9:8] == 2'b11) begin
                        init_done_q <= 1'b1;
                        state_q     <= ST_FRAME;
                    end else if (rom_entry[9:8] == 2'b10) begin
                        dly_q   <= dly_load;
                        state_q <= ST_DELAY;
                    end else begin
                        data_q  <= rom_entry[7:0];
                        dc_q    <= rom_entry[8];
                        src_q   <= SRC_ROM;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Never raise a request while the master still shows done.
                    if (!spi_send_done) begin
                        send_q  <= 1'b1;
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (spi_send_done) begin
                        send_q  <= 1'b0;
                        state_q <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!spi_send_done) begin
                        case (src_q)
                            SRC_PIX: begin
                                if (fcnt_q == FCNT_W'(FRAME_BYTES - 1)) begin
                                    fcnt_q       <= '0;
                                    frame_done_q <= 1'b1;
                                    state_q      <= ST_FRAME;
                                end else begin
                                    fcnt_q  <= fcnt_q + 1'b1;
                                    state_q <= ST_STREAM;
                                end
                            end
`ifdef SEQ_WINDOW_CMD_EN
                            SRC_WIN: begin
                                win_idx_q <= win_idx_q + 1'b1;
                                state_q   <= ST_WINDOW;
                            end
`endif
                            default: begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= ST_FETCH;
                            end
                        endcase
                    end
                end
                ST_DELAY: begin
                    if (dly_q == '0) begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ST_FETCH;
                    end else begin
                        dly_q <= dly_q - 1'b1;
                    end
                end
`ifdef SEQ_WINDOW_CMD_EN
                ST_WINDOW: begin
                    if (win_idx_q == 3'd6) begin
                        win_idx_q <= '0;
                        state_q   <= ST_STREAM;
                    end else begin
                        data_q  <= win_byte(win_idx_q);
                        dc_q    <= 1'b0;
                        src_q   <= SRC_WIN;
                        state_q <= ST_SEND;
                    end
                end
`endif
                ST_STREAM: begin
                    if (pix_valid) begin
                        data_q  <= pix_data;
                        dc_q    <= 1'b1;
                        src_q   <= SRC_PIX;
                        state_q <= ST_SEND;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // In STREAM nothing is outstanding, so ready follows valid for the one
    // cycle before the FSM leaves for SEND.
    assign pix_ready    = (state_q == ST_STREAM) && pix_valid;
    assign busy         = busy_q;
    assign init_done    = init_done_q;
    assign frame_done   = frame_done_q;
    assign spi_data_out = data_q;
    assign dc_in        = dc_q;
    assign spi_send     = send_q;

endmodule

// File: doc/spi_display_sequencer.md
SPI_DISPLAY_SEQUENCER -- requirements
Module: spi_display_sequencer

Interface
REQ-001 Parameter ROM_DEPTH, default 32: number of init ROM entries.
REQ-002 Parameter MS_CYCLES, default 100000: clk cycles per delay unit (1 ms at 100 MHz).
REQ-003 Parameter FRAME_BYTES, default 1024: data bytes per frame (128x64 monochrome).
REQ-004 Port clk  input  1  system clock; every register is clocked on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  one-cycle request to begin the init sequence.
REQ-007 Port busy  output  1  high from accepted start until return to IDLE.
REQ-008 Port init_done  output  1  level; high once the ROM sequence has completed.
REQ-009 Port pix_valid  input  1  requester has a frame byte on pix_data.
REQ-010 Port pix_data  input  8  frame byte.
REQ-011 Port pix_ready  output  1  byte accepted when pix_valid and pix_ready are both high.
REQ-012 Port frame_done  output  1  one-cycle pulse after the last byte of a frame completes.
REQ-013 Port spi_data_out  output  8  byte to the SPI master, registered.
REQ-014 Port dc_in  output  1  SPI master D/C (0 = command, 1 = data), registered.
REQ-015 Port spi_send  output  1  send request level to the SPI master.
REQ-016 Port spi_send_done  input  1  SPI master completion level; it is slow-clock derived and lasts many clk cycles.

Function
REQ-017 The ROM entry is 10 bits {type[1:0], payload[7:0]}: 00 = command byte (dc 0), 01 = data byte (dc 1), 10 = delay of payload x MS_CYCLES clk cycles, 11 = end of list.
REQ-018 The states are IDLE, FETCH, SEND, WAIT_DONE, WAIT_LOW, DELAY, STREAM and WINDOW (WINDOW only when compiled in).
REQ-019 IDLE: start moves the block to FETCH with the ROM index at 0; start is ignored in every other state.
REQ-020 FETCH: the block reads ROM[index] in one cycle, then decodes the entry.
- Byte entries go to SEND.
- A delay entry loads the delay counter and goes to DELAY.
- An end entry, or index = ROM_DEPTH, sets init_done and goes to STREAM.
REQ-021 SEND: spi_data_out and dc_in are stable before or in the same cycle that spi_send rises, and they hold until WAIT_LOW exits.
REQ-022 WAIT_DONE: spi_send stays high until spi_send_done is sampled high, then drops on the next clk edge; the block then enters WAIT_LOW.
REQ-023 WAIT_LOW: the block waits for spi_send_done low before issuing any further byte.
- This prevents the SPI master from re-triggering on a stale request.
- The block then returns to FETCH (index+1), STREAM or WINDOW as the byte source requires.
REQ-024 DELAY: the counter counts down to 0; a payload of 0 costs one cycle; the block then goes to FETCH with index+1.
REQ-025 STREAM: pix_ready is high for exactly one cycle when the block is ready for a byte.
- Ready means no send is outstanding and pix_valid is high.
- The accepted byte is sent with dc = 1.
- If pix_valid is low, the block stalls indefinitely with spi_send low.
REQ-026 The frame byte counter is log2(FRAME_BYTES) bits wide plus 1 bit.
- When the FRAME_BYTES-th byte finishes WAIT_LOW, frame_done pulses and the counter wraps to 0.
- The block then stays in STREAM (or enters WINDOW) for the next frame.
REQ-027 At most one byte is in flight at any time: spi_send never rises while spi_send_done is high.
REQ-028 busy is high in every state except IDLE; init_done and streaming persist until reset.

Reset
REQ-029 Asserting reset_n low at any time, including mid-byte or mid-delay, immediately forces the following, with no waiting on the SPI master:
- state = IDLE
- spi_send = 0, pix_ready = 0, frame_done = 0, busy = 0, init_done = 0
- spi_data_out = 0x00, dc_in = 0
- all counters and the ROM index = 0
REQ-030 After release, no activity occurs until start.

Configuration
REQ-031 With SEQ_WINDOW_CMD_EN defined, WINDOW runs before every frame: it sends 0x21, 0x00, 0x7F, 0x22, 0x00, 0x07, all with dc = 0, through the SEND/WAIT_DONE/WAIT_LOW handshake, and then enters STREAM.
REQ-032 Without SEQ_WINDOW_CMD_EN, the WINDOW state and its logic are absent, and frames stream directly after init or the previous frame.

Verification
REQ-033 ROM {0x0AE, 0x08D, 0x014, 0x20A, 0x0AF, 0x300}, with a bench SPI model giving done 200 cycles after send → bus bytes AE, 8D, 14 (dc 0); then ≥10*MS_CYCLES idle; then AF; then init_done = 1.
REQ-034 Hold spi_send_done high for 500 cycles after each byte → exactly one spi_send rise per byte; no duplicate bytes observed.
REQ-035 FRAME_BYTES = 4, pix_valid toggling 1010… with data 0x11..0x44 → bytes 11, 22, 33, 44 with dc 1; frame_done pulses once, one cycle after the 0x44 handshake.
REQ-036 reset_n pulsed low during WAIT_DONE of byte 0x8D → spi_send = 0 within the same cycle; all outputs return to reset values; the next start replays from ROM[0].
REQ-037 start asserted while busy → ignored; the ROM index is unchanged.
REQ-038 With SEQ_WINDOW_CMD_EN defined → 21 00 7F 22 00 07 precede each frame; without it → the first bus byte after init is pix_data.
